ids_bus_arb: RTL and testbench
==============================

Name: ids_bus_arb

Overview:
- Parametrised successor to the fixed-master SoC bus: N bus masters share one request/grant path into M memory-mapped slaves.
- Arbitration is round-robin with a bounded hold (lock) window.
- Slaves are selected from a parametrised base/mask address map, with one-cycle registered read return.
- Sits between masters (RV DMEM, SPI slave, DMA, future masters) and slaves (DMEM, PIM buffer, UART, PIM port).

Parameters:
- XLEN, 32, address/data width.
- NUM_M, 4, number of masters (2..8).
- NUM_S, 4, number of slaves (1..8).
- S_BASE, {32'h1000_0000, 32'h2000_0000, 32'h8000_0000, 32'h4000_0000}, slave base addresses (array of NUM_S).
- S_MASK, {32'hFFFF_0000, 32'hFFF0_0000, 32'hFFFF_FFF0, 32'hFFFF_FF00}, slave match masks. Slave s hits when (addr & S_MASK[s]) == S_BASE[s]; the lowest index wins on overlap.
- MAX_HOLD, 16, maximum consecutive cycles one master keeps the grant while others request (1..255).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_m_req  in  NUM_M  per-master request.
- o_m_gnt  out  NUM_M  one-hot grant.
- i_m_addr  in  NUM_M*XLEN  master addresses, master k at slice k.
- i_m_write  in  NUM_M  write strobe.
- i_m_read  in  NUM_M  read strobe.
- i_m_size  in  NUM_M*4  byte-enable/size code.
- i_m_wdata  in  NUM_M*XLEN  write data.
- o_m_rdata  out  XLEN  read data, broadcast to all masters.
- o_m_rvalid  out  NUM_M  one-hot read-data valid.
- o_s_sel  out  NUM_S  one-hot slave select.
- o_s_addr  out  XLEN  slave address.
- o_s_write  out  1  slave write.
- o_s_read  out  1  slave read.
- o_s_size  out  4  slave size.
- o_s_wdata  out  XLEN  slave write data.
- i_s_rdata  in  NUM_S*XLEN  slave read data, valid one cycle after o_s_read.
- o_dec_err  out  1  one-cycle pulse on an access that decodes to no slave.

Behaviour:
- Reset (i_rst high, asynchronous): o_m_gnt=0, o_m_rvalid=0, o_dec_err=0, state=IDLE, rr pointer=0, hold counter=0. Slave outputs are combinationally 0 while no grant is held.
- FSM states: IDLE, OWN.
  - IDLE: when any i_m_req is high, pick the winner by round-robin, searching from pointer upward with wrap. Register o_m_gnt one-hot next cycle, go to OWN, hold=0. Grant latency is 1 cycle after request.
  - OWN: the owner's address, strobes, size and wdata are muxed combinationally to the slave side. o_s_sel is decoded from the owner's address; o_s_read/o_s_write are gated by o_s_sel != 0.
  - OWN -> IDLE when the owner's req drops: o_m_gnt=0 next cycle, pointer=owner+1 (mod NUM_M).
  - OWN with other requests pending: hold increments each cycle. When hold reaches MAX_HOLD-1, a forced handover occurs: the next round-robin winner (excluding the owner) is granted directly, with no IDLE bubble, and pointer=owner+1.
  - OWN with no other requester: hold saturates at 0 and the owner keeps the grant indefinitely.
- Reads: a read accepted in cycle t gives o_m_rvalid[owner]=1 and o_m_rdata = i_s_rdata of the slave selected at t, in cycle t+1. Slave index and master index are registered at t. This holds even if the grant changes or is dropped at t+1.
- Writes: complete in the cycle they are presented. No response.
- read and write both high: treat as a write, ignore the read, and produce no rvalid.
- Decode miss:
  - o_s_sel=0 and no slave strobe.
  - o_dec_err pulses in the same cycle (registered, visible t+1).
  - A read miss still returns rvalid at t+1 with rdata=32'h0.
- Simultaneous requests from all masters at reset exit: master 0 wins first, then 1, 2, 3 in order.
- Reset mid-transfer: a pending rvalid is cancelled and the grant is dropped immediately.

Decomposition:
- Shared package ids_bus_pkg:
  - size codes SZ_BYTE=4'b0001, SZ_HALF=4'b0011, SZ_WORD=4'b1111;
  - default map constants and the state enum {IDLE, OWN}.
- Sub-module ids_rr_arbiter, parametrised on NUM_M:
  - inputs: request vector, pointer, exclude mask;
  - output: one-hot winner plus a valid flag;
  - purely combinational, fixed-priority search over a doubled vector.

Test Plan:
- Single master: m1 reads 0x1000_0004 while DMEM returns 0xCAFE_0001 -> gnt[1] at t+1, o_s_sel=4'b0001, rvalid[1] with rdata 0xCAFE_0001 one cycle after the read.
- Round-robin: all four req held, each master drops req after one access -> grant order 0,1,2,3,0, with one IDLE cycle between owners.
- Hold limit: MAX_HOLD=4, m0 holds req, m2 also requesting -> gnt switches 0->2 after exactly 4 OWN cycles with no gap. m0 alone for 20 cycles -> no switch.
- Decode miss: m3 read at 0x5000_0000 -> o_s_sel=0, o_dec_err pulse, rvalid[3] with rdata 0.
- Overlap and late rvalid: address 0x4000_0010 with PIM mapped -> sel index 3. Owner drops req in the cycle after its read -> rvalid still delivered to that owner.
- Async reset mid-read: i_rst asserted between read and return -> rvalid=0, gnt=0 immediately; after release m0 wins first.

Source files
------------

// File: rtl/ids_bus_pkg.sv
// ----------------------------------------------------------------------------
// ids_bus_pkg
// Shared definitions for the ids bus arbiter and its round-robin picker:
//   - byte-enable / size codes carried on i_m_size / o_s_size
//   - default widths, master/slave counts, hold window and address map
//   - the arbiter FSM state enum (IDLE, OWN)
// No ports (package).
// ----------------------------------------------------------------------------
package ids_bus_pkg;

  // Size codes double as byte-enable masks for the low lanes.
  localparam logic [3:0] SZ_BYTE = 4'b0001;
  localparam logic [3:0] SZ_HALF = 4'b0011;
  localparam logic [3:0] SZ_WORD = 4'b1111;

  localparam int DEF_XLEN     = 32;
  localparam int DEF_NUM_M    = 4;
  localparam int DEF_NUM_S    = 4;
  localparam int DEF_MAX_HOLD = 16;

  // Default map: 0 = DMEM, 1 = PIM buffer, 2 = UART, 3 = PIM port.
  localparam logic [31:0] DEF_S_BASE [4] = '{
    32'h1000_0000, 32'h2000_0000, 32'h8000_0000, 32'h4000_0000
  };
  localparam logic [31:0] DEF_S_MASK [4] = '{
    32'hFFFF_0000, 32'hFFF0_0000, 32'hFFFF_FFF0, 32'hFFFF_FF00
  };

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_e;

endpackage

// File: rtl/ids_rr_arbiter.sv
// ----------------------------------------------------------------------------
// ids_rr_arbiter
// Purely combinational round-robin picker. Searches the request vector
// upward from a start pointer, wrapping past NUM_M-1 back to 0, skipping any
// master set in the exclude mask. Implemented as a fixed-priority search over
// the request vector concatenated with itself, restricted to the window
// [ptr, ptr+NUM_M).
//
// Ports:
//   req_i   [NUM_M]          request vector
//   ptr_i   [clog2(NUM_M)]   index the search starts from
//   excl_i  [NUM_M]          masters that may not win
//   gnt_o   [NUM_M]          one-hot winner (0 when none)
//   valid_o                  a winner exists
// ----------------------------------------------------------------------------
module ids_rr_arbiter #(
  parameter int NUM_M = 4
) (
  input  logic [NUM_M-1:0]         req_i,
  input  logic [$clog2(NUM_M)-1:0] ptr_i,
  input  logic [NUM_M-1:0]         excl_i,
  output logic [NUM_M-1:0]         gnt_o,
  output logic                     valid_o
);

  // Wide enough to hold ptr + NUM_M - 1 without overflow.
  localparam int DW = $clog2(2 * NUM_M);

  logic [NUM_M-1:0]   masked;
  logic [2*NUM_M-1:0] dbl;
  logic [2*NUM_M-1:0] dbl_gnt;
  logic [DW-1:0]      lo;
  logic [DW-1:0]      hi;
  logic               found;

  always_comb begin
    masked  = req_i & ~excl_i;
    dbl     = {masked, masked};
    lo      = DW'(ptr_i);
    hi      = lo + DW'(NUM_M);
    dbl_gnt = '0;
    found   = 1'b0;
    for (int j = 0; j < 2 * NUM_M; j++) begin
      if (!found && dbl[j] && (DW'(j) >= lo) && (DW'(j) < hi)) begin
        dbl_gnt[j] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  // Fold the doubled one-hot back onto master indices.
  assign gnt_o   = dbl_gnt[NUM_M-1:0] | dbl_gnt[2*NUM_M-1:NUM_M];
  assign valid_o = found;

endmodule

// File: rtl/ids_bus_arb.sv
// ----------------------------------------------------------------------------
// ids_bus_arb
// N-master / M-slave shared bus. Round-robin arbitration with a bounded hold
// window, base/mask slave decode (lowest index wins on overlap) and one-cycle
// registered read return.
//
// Handshake: a master raises i_m_req and keeps it high for as long as it
// wants the bus. o_m_gnt[k] rises the cycle after the request is seen. Every
// cycle in which master k holds the grant and drives a strobe is one access;
// writes complete in that cycle, reads return o_m_rvalid[k] with o_m_rdata
// exactly one cycle later, whatever the grant does in between. Dropping
// i_m_req releases the grant one cycle later.
//
// Ports:
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_m_req/o_m_gnt   per-master request, one-hot grant
//   i_m_addr/write/read/size/wdata   per-master access, master k at slice k
//   o_m_rdata         read data, broadcast; o_m_rvalid one-hot target
//   o_s_*             slave side, combinationally muxed from the owner
//   i_s_rdata         per-slave read data, valid one cycle after o_s_read
//   o_dec_err         registered pulse for an access that hit no slave
//   o_dbg_state       arbiter FSM state
// ----------------------------------------------------------------------------
module ids_bus_arb
  import ids_bus_pkg::*;
#(
  parameter int               XLEN              = DEF_XLEN,
  parameter int               NUM_M             = DEF_NUM_M,
  parameter int               NUM_S             = DEF_NUM_S,
  parameter logic [XLEN-1:0]  S_BASE [NUM_S]    = DEF_S_BASE,
  parameter logic [XLEN-1:0]  S_MASK [NUM_S]    = DEF_S_MASK,
  parameter int               MAX_HOLD          = DEF_MAX_HOLD
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [NUM_M-1:0]        i_m_req,
  output logic [NUM_M-1:0]        o_m_gnt,
  input  logic [NUM_M*XLEN-1:0]   i_m_addr,
  input  logic [NUM_M-1:0]        i_m_write,
  input  logic [NUM_M-1:0]        i_m_read,
  input  logic [NUM_M*4-1:0]      i_m_size,
  input  logic [NUM_M*XLEN-1:0]   i_m_wdata,
  output logic [XLEN-1:0]         o_m_rdata,
  output logic [NUM_M-1:0]        o_m_rvalid,
  output logic [NUM_S-1:0]        o_s_sel,
  output logic [XLEN-1:0]         o_s_addr,
  output logic                    o_s_write,
  output logic                    o_s_read,
  output logic [3:0]              o_s_size,
  output logic [XLEN-1:0]         o_s_wdata,
  input  logic [NUM_S*XLEN-1:0]   i_s_rdata,
  output logic                    o_dec_err,
  output state_e                  o_dbg_state
);

  localparam int         MW        = $clog2(NUM_M);
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  // Arbitration state
  state_e           state_q, state_d;
  logic [NUM_M-1:0] gnt_q, gnt_d;
  logic [MW-1:0]    ptr_q, ptr_d;
  logic [7:0]       hold_q, hold_d;

  // Read return / error state
  logic [NUM_M-1:0] rvalid_q, rvalid_d;
  logic [NUM_S-1:0] rsel_q, rsel_d;
  logic             dec_err_q, dec_err_d;

  // Owner view
  logic [MW-1:0]    owner_idx;
  logic [MW-1:0]    owner_inc;
  logic             own_req;
  logic [XLEN-1:0]  own_addr;
  logic [XLEN-1:0]  own_wdata;
  logic [3:0]       own_size;
  logic             own_rd;
  logic             own_wr;
  logic [NUM_S-1:0] s_sel;
  logic             rd_acc;
  logic             any_acc;

  // Arbiter hookup
  logic [MW-1:0]    arb_ptr;
  logic [NUM_M-1:0] arb_excl;
  logic [NUM_M-1:0] arb_gnt;
  logic             arb_valid;

  // --------------------------------------------------------------------------
  // Owner index and owner-side mux. gnt_q is one-hot or zero, so an OR-mux
  // yields zeros on every field while nobody owns the bus.
  // --------------------------------------------------------------------------
  always_comb begin
    owner_idx = '0;
    own_addr  = '0;
    own_wdata = '0;
    own_size  = '0;
    own_rd    = 1'b0;
    own_wr    = 1'b0;
    for (int k = 0; k < NUM_M; k++) begin
      if (gnt_q[k]) begin
        owner_idx = MW'(k);
        own_addr  = i_m_addr[k*XLEN +: XLEN];
        own_wdata = i_m_wdata[k*XLEN +: XLEN];
        own_size  = i_m_size[k*4 +: 4];
        own_rd    = i_m_read[k];
        own_wr    = i_m_write[k];
      end
    end
  end

  assign owner_inc = (owner_idx == MW'(NUM_M - 1)) ? '0 : owner_idx + MW'(1);
  assign own_req   = |(i_m_req & gnt_q);

  // Decode walks from the top index down so the lowest matching slave is
  // the one left standing.
  always_comb begin
    s_sel = '0;
    if (|gnt_q) begin
      for (int s = NUM_S - 1; s >= 0; s--) begin
        if ((own_addr & S_MASK[s]) == S_BASE[s]) begin
          s_sel    = '0;
          s_sel[s] = 1'b1;
        end
      end
    end
  end

  // While owning, search starts after the owner and skips it, which is
  // exactly the forced-handover candidate. In IDLE, search from the pointer.
  assign arb_ptr  = (state_q == OWN) ? owner_inc : ptr_q;
  assign arb_excl = (state_q == OWN) ? gnt_q : '0;

  ids_rr_arbiter #(
    .NUM_M (NUM_M)
  ) u_rr (
    .req_i   (i_m_req),
    .ptr_i   (arb_ptr),
    .excl_i  (arb_excl),
    .gnt_o   (arb_gnt),
    .valid_o (arb_valid)
  );

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          state_d = OWN;
          gnt_d   = arb_gnt;
          hold_d  = '0;
        end
      end
      OWN: begin
        if (!own_req) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = owner_inc;
          hold_d  = '0;
        end else if (arb_valid) begin
          // Someone else is waiting: count down the hold window, then hand
          // the bus straight to the next round-robin winner.
          if (hold_q == HOLD_LAST) begin
            gnt_d  = arb_gnt;
            ptr_d  = owner_inc;
            hold_d = '0;
          end else begin
            hold_d = hold_q + 8'd1;
          end
        end else begin
          hold_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs (slave side is combinational from the owner)
  // --------------------------------------------------------------------------
  always_comb begin
    o_s_sel   = s_sel;
    o_s_addr  = own_addr;
    o_s_size  = own_size;
    o_s_wdata = own_wdata;
    // A write wins over a simultaneous read.
    o_s_write = own_wr & (|s_sel);
    o_s_read  = own_rd & ~own_wr & (|s_sel);
  end

  assign o_m_gnt     = gnt_q;
  assign o_dbg_state = state_q;

  // --------------------------------------------------------------------------
  // Read return and decode error. A read miss still returns rvalid; its
  // rsel_q is zero so the data mux returns zero.
  // --------------------------------------------------------------------------
  assign rd_acc    = own_rd & ~own_wr;
  assign any_acc   = own_rd | own_wr;
  assign rvalid_d  = rd_acc ? gnt_q : '0;
  assign rsel_d    = rd_acc ? s_sel : '0;
  assign dec_err_d = any_acc & ~(|s_sel);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rvalid_q  <= '0;
      rsel_q    <= '0;
      dec_err_q <= 1'b0;
    end else begin
      rvalid_q  <= rvalid_d;
      rsel_q    <= rsel_d;
      dec_err_q <= dec_err_d;
    end
  end

  always_comb begin
    o_m_rdata = '0;
    for (int s = 0; s < NUM_S; s++) begin
      if (rsel_q[s]) o_m_rdata = i_s_rdata[s*XLEN +: XLEN];
    end
  end

  assign o_m_rvalid = rvalid_q;
  assign o_dec_err  = dec_err_q;

endmodule

// File: tb/tb_ids_bus_arb.sv
module tb_ids_bus_arb;
  import ids_bus_pkg::*;

  localparam int XLEN     = 32;
  localparam int NUM_M    = 4;
  localparam int NUM_S    = 4;
  localparam int MAX_HOLD = 4;

  localparam logic [31:0] MAP_BASE [4] = '{
    32'h1000_0000, 32'h2000_0000, 32'h8000_0000, 32'h4000_0000
  };
  localparam logic [31:0] MAP_MASK [4] = '{
    32'hFFFF_0000, 32'hFFF0_0000, 32'hFFFF_FFF0, 32'hFFFF_FF00
  };
  localparam logic [31:0] ADDR_TBL [8] = '{
    32'h1000_0004, 32'h1000_FFFC, 32'h2003_0008, 32'h8000_000C,
    32'h8000_0010, 32'h4000_0010, 32'h4000_00FC, 32'h5000_0000
  };

  // ---------------------------------------------------------------- signals
  logic                  clk;
  logic                  rst;
  logic [NUM_M-1:0]      m_req;
  logic [NUM_M-1:0]      m_gnt;
  logic [NUM_M*XLEN-1:0] m_addr;
  logic [NUM_M-1:0]      m_wr;
  logic [NUM_M-1:0]      m_rd;
  logic [NUM_M*4-1:0]    m_size;
  logic [NUM_M*XLEN-1:0] m_wdata;
  logic [XLEN-1:0]       m_rdata;
  logic [NUM_M-1:0]      m_rvalid;
  logic [NUM_S-1:0]      s_sel;
  logic [XLEN-1:0]       s_addr;
  logic                  s_write;
  logic                  s_read;
  logic [3:0]            s_size;
  logic [XLEN-1:0]       s_wdata;
  logic [NUM_S*XLEN-1:0] s_rdata;
  logic                  dec_err;
  state_e                dbg_state;

  ids_bus_arb #(
    .XLEN     (XLEN),
    .NUM_M    (NUM_M),
    .NUM_S    (NUM_S),
    .S_BASE   (MAP_BASE),
    .S_MASK   (MAP_MASK),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_m_req     (m_req),
    .o_m_gnt     (m_gnt),
    .i_m_addr    (m_addr),
    .i_m_write   (m_wr),
    .i_m_read    (m_rd),
    .i_m_size    (m_size),
    .i_m_wdata   (m_wdata),
    .o_m_rdata   (m_rdata),
    .o_m_rvalid  (m_rvalid),
    .o_s_sel     (s_sel),
    .o_s_addr    (s_addr),
    .o_s_write   (s_write),
    .o_s_read    (s_read),
    .o_s_size    (s_size),
    .o_s_wdata   (s_wdata),
    .i_s_rdata   (s_rdata),
    .o_dec_err   (dec_err),
    .o_dbg_state (dbg_state)
  );

  // ------------------------------------------------------ clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------------ scoreboard
  int n_checks = 0;
  int n_errors = 0;

  // Reference model: owner index (-1 = none), search pointer, hold count,
  // pending decode error, and reads awaiting return {master, slave|FF}.
  int          m_owner = -1;
  int          m_ptr   = 0;
  int          m_hold  = 0;
  logic        m_dec_pend = 1'b0;
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int decode(input logic [31:0] a);
    for (int s = 0; s < NUM_S; s++) begin
      if ((a & MAP_MASK[s]) == MAP_BASE[s]) return s;
    end
    return -1;
  endfunction

  function automatic int pick(input int start, input int skip);
    int k;
    for (int i = 0; i < NUM_M; i++) begin
      k = (start + i) % NUM_M;
      if (k != skip && m_req[k]) return k;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner    = -1;
    m_ptr      = 0;
    m_hold     = 0;
    m_dec_pend = 1'b0;
    exp_q.delete();
  endtask

  // Arbitration rules applied to the requests seen in the current cycle.
  task automatic model_arbitrate();
    int nxt;
    if (m_owner < 0) begin
      nxt = pick(m_ptr, -1);
      if (nxt >= 0) begin
        m_owner = nxt;
        m_hold  = 0;
      end
    end else if (!m_req[m_owner]) begin
      m_ptr   = (m_owner + 1) % NUM_M;
      m_owner = -1;
      m_hold  = 0;
    end else begin
      nxt = pick((m_owner + 1) % NUM_M, m_owner);
      if (nxt < 0) begin
        m_hold = 0;
      end else if (m_hold == MAX_HOLD - 1) begin
        m_ptr   = (m_owner + 1) % NUM_M;
        m_owner = nxt;
        m_hold  = 0;
      end else begin
        m_hold = m_hold + 1;
      end
    end
  endtask

  // ---------------------------------------------------------------- drivers
  task automatic set_m(input int k, input logic r, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [3:0] sz, input logic [31:0] wd);
    m_req[k]                 = r;
    m_rd[k]                  = rd;
    m_wr[k]                  = wr;
    m_addr[k*XLEN +: XLEN]   = a;
    m_size[k*4 +: 4]         = sz;
    m_wdata[k*XLEN +: XLEN]  = wd;
  endtask

  task automatic idle_all();
    for (int k = 0; k < NUM_M; k++) set_m(k, 1'b0, 1'b0, 1'b0, 32'h0, SZ_WORD, 32'h0);
  endtask

  // Called at a falling edge with inputs already driven. Checks every output
  // of the current cycle against the model, advances the model, and returns
  // at the next falling edge.
  task automatic cycle();
    int               own;
    int               sel;
    int               e_m;
    int               e_s;
    logic [31:0]      a;
    logic [31:0]      exp_rdata;
    logic             rd;
    logic             wr;
    logic [15:0]      e;
    logic [NUM_M-1:0] exp_gnt;
    logic [NUM_M-1:0] exp_rv;
    logic [NUM_S-1:0] exp_sel;
    state_e           exp_st;
    #1;
    own     = m_owner;
    exp_gnt = '0;
    if (own >= 0) exp_gnt[own] = 1'b1;
    exp_st  = (own >= 0) ? OWN : IDLE;
    check("gnt", 64'(m_gnt), 64'(exp_gnt));
    check("state", 64'(dbg_state), 64'(exp_st));

    if (exp_q.size() != 0) begin
      e         = exp_q.pop_front();
      e_m       = int'(e[15:8]);
      e_s       = int'(e[7:0]);
      exp_rv    = '0;
      exp_rv[e_m] = 1'b1;
      exp_rdata = (e_s == 255) ? 32'h0 : s_rdata[e_s*XLEN +: XLEN];
      check("rvalid", 64'(m_rvalid), 64'(exp_rv));
      check("rdata", 64'(m_rdata), 64'(exp_rdata));
    end else begin
      check("rvalid_idle", 64'(m_rvalid), 64'h0);
    end
    check("dec_err", 64'(dec_err), 64'(m_dec_pend));

    m_dec_pend = 1'b0;
    if (own >= 0) begin
      a       = m_addr[own*XLEN +: XLEN];
      rd      = m_rd[own];
      wr      = m_wr[own];
      sel     = decode(a);
      exp_sel = '0;
      if (sel >= 0) exp_sel[sel] = 1'b1;
      check("s_sel", 64'(s_sel), 64'(exp_sel));
      check("s_addr", 64'(s_addr), 64'(a));
      check("s_write", 64'(s_write), 64'(wr && sel >= 0));
      check("s_read", 64'(s_read), 64'(rd && !wr && sel >= 0));
      check("s_size", 64'(s_size), 64'(m_size[own*4 +: 4]));
      check("s_wdata", 64'(s_wdata), 64'(m_wdata[own*XLEN +: XLEN]));
      if ((rd || wr) && sel < 0) m_dec_pend = 1'b1;
      if (rd && !wr) exp_q.push_back({8'(own), (sel < 0) ? 8'hFF : 8'(sel)});
    end else begin
      check("s_sel_idle", 64'(s_sel), 64'h0);
      check("s_strobe_idle", 64'({s_read, s_write}), 64'h0);
      check("s_addr_idle", 64'(s_addr), 64'h0);
      check("s_wdata_idle", 64'(s_wdata), 64'h0);
    end
    model_arbitrate();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_gnt(input int k, input int max_cycles);
    for (int g = 0; g < max_cycles && !m_gnt[k]; g++) cycle();
    check($sformatf("wait_gnt%0d", k), 64'(m_gnt[k]), 64'h1);
  endtask

  function automatic logic [31:0] pick_addr();
    int idx;
    idx = $urandom_range(0, 8);
    if (idx == 8) return $urandom;
    return ADDR_TBL[idx];
  endfunction

  function automatic logic [3:0] pick_size();
    case ($urandom_range(0, 2))
      0:       return SZ_BYTE;
      1:       return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

  // ------------------------------------------------------------------ main
  int   order_q[$];
  logic [NUM_M-1:0] prev_gnt;
  logic served [NUM_M];
  int   n0;
  int   guard;
  logic r;

  initial begin
    rst     = 1'b1;
    s_rdata = '0;
    m_req = '0; m_rd = '0; m_wr = '0; m_addr = '0; m_size = '0; m_wdata = '0;
    idle_all();
    #1;
    check("rst_gnt", 64'(m_gnt), 64'h0);
    check("rst_rvalid", 64'(m_rvalid), 64'h0);
    check("rst_dec_err", 64'(dec_err), 64'h0);
    check("rst_s_sel", 64'(s_sel), 64'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (2) cycle();

    // Single master read from DMEM.
    s_rdata[0*XLEN +: XLEN] = 32'hCAFE_0001;
    set_m(1, 1'b1, 1'b1, 1'b0, 32'h1000_0004, SZ_WORD, 32'h0);
    cycle();
    wait_gnt(1, 4);
    cycle();
    check("single_rvalid", 64'(m_rvalid), 64'h2);
    check("single_rdata", 64'(m_rdata), 64'hCAFE_0001);
    set_m(1, 1'b0, 1'b0, 1'b0, 32'h0, SZ_WORD, 32'h0);
    repeat (2) cycle();

    // Decode miss from master 3.
    set_m(3, 1'b1, 1'b1, 1'b0, 32'h5000_0000, SZ_WORD, 32'h0);
    wait_gnt(3, 4);
    cycle();
    check("miss_dec_err", 64'(dec_err), 64'h1);
    check("miss_rvalid", 64'(m_rvalid), 64'h8);
    check("miss_rdata", 64'(m_rdata), 64'h0);
    set_m(3, 1'b0, 1'b0, 1'b0, 32'h0, SZ_WORD, 32'h0);
    repeat (2) cycle();

    // PIM port read, owner drops request right after its read.
    s_rdata[3*XLEN +: XLEN] = 32'h1234_5678;
    set_m(2, 1'b1, 1'b1, 1'b0, 32'h4000_0010, SZ_HALF, 32'h0);
    wait_gnt(2, 4);
    cycle();
    set_m(2, 1'b0, 1'b0, 1'b0, 32'h0, SZ_WORD, 32'h0);
    check("late_rvalid", 64'(m_rvalid), 64'h4);
    check("late_rdata", 64'(m_rdata), 64'h1234_5678);
    repeat (2) cycle();

    // Asynchronous reset between a read and its return.
    set_m(1, 1'b1, 1'b1, 1'b0, 32'h1000_0000, SZ_WORD, 32'h0);
    wait_gnt(1, 4);
    cycle();
    rst = 1'b1;
    #1;
    check("midrst_rvalid", 64'(m_rvalid), 64'h0);
    check("midrst_gnt", 64'(m_gnt), 64'h0);
    model_reset();
    for (int k = 0; k < NUM_M; k++) begin
      served[k] = 1'b0;
      set_m(k, 1'b1, 1'b1, 1'b0, 32'h1000_0000 + 32'(k * 4), SZ_WORD, $urandom);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // All masters requesting at reset exit, one access each.
    prev_gnt = '0;
    guard    = 0;
    while (order_q.size() < 5 && guard < 80) begin
      cycle();
      guard++;
      if (m_gnt != '0 && m_gnt != prev_gnt) begin
        for (int k = 0; k < NUM_M; k++) if (m_gnt[k]) order_q.push_back(k);
      end
      prev_gnt = m_gnt;
      for (int k = 0; k < NUM_M; k++) begin
        if (m_gnt[k] && !served[k]) begin
          served[k] = 1'b1;
        end else if (m_gnt[k] && served[k]) begin
          set_m(k, 1'b0, 1'b0, 1'b0, 32'h1000_0000, SZ_WORD, 32'h0);
        end else if (!m_gnt[k] && served[k]) begin
          served[k] = 1'b0;
          set_m(k, 1'b1, 1'b1, 1'b0, 32'h1000_0000 + 32'(k * 4), SZ_WORD, $urandom);
        end
      end
    end
    check("rr_len", 64'(order_q.size()), 64'd5);
    for (int i = 0; i < order_q.size(); i++) check($sformatf("rr_order%0d", i), 64'(order_q[i]), 64'(i % NUM_M));
    idle_all();
    repeat (3) cycle();

    // Hold limit: m0 owns, m2 starts waiting on m0's first owned cycle.
    set_m(0, 1'b1, 1'b0, 1'b1, 32'h1000_0100, SZ_WORD, 32'hA5A5_0000);
    wait_gnt(0, 4);
    set_m(2, 1'b1, 1'b0, 1'b1, 32'h2000_0000, SZ_BYTE, 32'h0000_005A);
    n0 = 0;
    for (int g = 0; g < 20 && m_gnt == 4'b0001; g++) begin
      n0++;
      cycle();
    end
    check("hold_cycles", 64'(n0), 64'(MAX_HOLD));
    check("hold_next", 64'(m_gnt), 64'h4);
    idle_all();
    repeat (3) cycle();

    // m0 alone keeps the bus indefinitely.
    set_m(0, 1'b1, 1'b0, 1'b1, 32'h1000_0200, SZ_WORD, 32'h0);
    wait_gnt(0, 4);
    n0 = 0;
    repeat (20) begin
      if (m_gnt == 4'b0001) n0++;
      cycle();
    end
    check("alone_cycles", 64'(n0), 64'd20);
    idle_all();
    repeat (3) cycle();

    // Randomized traffic.
    for (int c = 0; c < 2000; c++) begin
      for (int k = 0; k < NUM_M; k++) begin
        r = m_req[k] ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 3) == 0);
        set_m(k, r, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
              pick_addr(), pick_size(), $urandom);
      end
      for (int s = 0; s < NUM_S; s++) s_rdata[s*XLEN +: XLEN] = $urandom;
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
